// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN memory-subsystem sequencer.
//   state_t         - sequencer FSM states
//   ADDR_*          - host register map (3-bit address)
//   DEF_*           - default region sizes and layer timeout
//   CTRL_* / STAT_* - control and status register bit positions
//   layer_onehot()  - one-hot start vector for a layer index
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int unsigned NUM_REGIONS = 5;
    localparam int unsigned NUM_LAYERS  = 4;

    // Register map
    localparam logic [2:0] ADDR_INPUT  = 3'd0;
    localparam logic [2:0] ADDR_L1     = 3'd1;
    localparam logic [2:0] ADDR_L2     = 3'd2;
    localparam logic [2:0] ADDR_L3     = 3'd3;
    localparam logic [2:0] ADDR_L4     = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;
    localparam logic [2:0] ADDR_RESULT = 3'd7;

    // Default region sizes in bytes
    localparam int unsigned DEF_INPUT_SIZE     = 10000;
    localparam int unsigned DEF_L1_SIZE        = 400;
    localparam int unsigned DEF_L2_SIZE        = 12800;
    localparam int unsigned DEF_L3_SIZE        = 230400;
    localparam int unsigned DEF_L4_SIZE        = 10600;
    localparam int unsigned DEF_RESULT_SIZE    = 53;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16777216;

    // Control register bits
    localparam int CTRL_GO    = 0;
    localparam int CTRL_CLEAR = 1;

    // Status register bits ([4:0] are the per-region loaded flags)
    localparam int STAT_BUSY = 5;
    localparam int STAT_DONE = 6;
    localparam int STAT_ERR  = 7;

    function automatic logic [NUM_LAYERS-1:0] layer_onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

endpackage

// File: rtl/cnn_region_counter.sv
// cnn_region_counter: saturating fill counter for one load region.
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - synchronous zero of the count
//   inc          - one byte offered to this region
//   cnt          - bytes accepted so far (next RAM write address)
//   full         - region holds SIZE bytes
//   ovf          - strobe: a byte was offered while full (dropped)
module cnn_region_counter #(
    parameter int unsigned W    = 19,
    parameter int unsigned SIZE = 400
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         ovf
);

    assign full = (cnt == W'(SIZE));
    assign ovf  = inc && full;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !full) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cnn_sequencer.sv
// cnn_sequencer: host-facing control block of the CNN memory subsystem.
//   Bus:    chipselect, write, read, address[2:0], writedata[7:0], readdata[7:0]
//           (read latency 1). Addresses 0..4 load regions, 5 control,
//           6 status, 7 auto-incrementing result readout.
//   Load:   load_we, load_sel, load_addr, load_data - byte writes into the
//           input and four weight RAMs.
//   Layers: layer_start (one-hot pulse), layer_done (per-layer pulse),
//           buf_sel (ping-pong buffer holding the current layer's source).
//   Result: res_addr / res_rdata - result RAM read port (1-cycle latency).
//   irq:    level interrupt raised on completion or error.
module cnn_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned INPUT_SIZE     = DEF_INPUT_SIZE,
    parameter int unsigned L1_SIZE        = DEF_L1_SIZE,
    parameter int unsigned L2_SIZE        = DEF_L2_SIZE,
    parameter int unsigned L3_SIZE        = DEF_L3_SIZE,
    parameter int unsigned L4_SIZE        = DEF_L4_SIZE,
    parameter int unsigned RESULT_SIZE    = DEF_RESULT_SIZE,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [7:0]        writedata,
    output logic [7:0]        readdata,
    output logic              load_we,
    output logic [2:0]        load_sel,
    output logic [ADDR_W-1:0] load_addr,
    output logic [7:0]        load_data,
    output logic [3:0]        layer_start,
    input  logic [3:0]        layer_done,
    output logic              buf_sel,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [7:0]        res_rdata,
    output logic              irq
);

    localparam int unsigned SIZES [NUM_REGIONS] =
        '{INPUT_SIZE, L1_SIZE, L2_SIZE, L3_SIZE, L4_SIZE};

    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam int unsigned RW = ($clog2(RESULT_SIZE) < 1) ? 1 : $clog2(RESULT_SIZE);
    localparam logic [RW-1:0] RES_LAST = RW'(RESULT_SIZE - 1);

    // Buffer 1 occupies the upper half of the activation address space.
    localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(1) << (ADDR_W - 1);

    state_t            state;
    logic [1:0]        layer_idx;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     res_idx;
    logic              ovf_q;
    logic [7:0]        readdata_q;
    logic              rd_res_q;

    logic [ADDR_W-1:0] cnt [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] inc, full, ovf_strobe;
    logic [ADDR_W-1:0] sel_cnt;
    logic [7:0]        status;

    // Bus decode. A simultaneous read and write is treated as a write only.
    logic wr, rd, load_wr, clear, go, accept, ovf_set, busy;

    assign wr      = chipselect && write;
    assign rd      = chipselect && read && !write;
    assign load_wr = wr && (address <= ADDR_L4);
    assign clear   = wr && (address == ADDR_CTRL) && writedata[CTRL_CLEAR];
    assign go      = wr && (address == ADDR_CTRL) && writedata[CTRL_GO] &&
                     !writedata[CTRL_CLEAR] && (state == ST_LOAD) && (&full);
    assign busy    = (state == ST_START) || (state == ST_WAIT);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        inc     = '0;
        sel_cnt = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (address == 3'(r)) begin
                inc[r]  = load_wr && (state == ST_LOAD);
                sel_cnt = cnt[r];
            end
        end
    end

    assign accept  = |(inc & ~full);
    assign ovf_set = (|ovf_strobe) || (load_wr && (state != ST_LOAD));

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        cnn_region_counter #(
            .W    (ADDR_W),
            .SIZE (SIZES[g])
        ) u_counter (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .inc     (inc[g]),
            .cnt     (cnt[g]),
            .full    (full[g]),
            .ovf     (ovf_strobe[g])
        );
    end

    assign status = {(state == ST_ERR) || ovf_q, state == ST_DONE, busy, full};

    // Result address is a pure function of registered state; the result
    // always ends up in buffer 0 after an even number of layers.
    assign res_addr = (state == ST_DONE)
                    ? ((buf_sel ? BUF1_BASE : '0) + ADDR_W'(res_idx))
                    : '0;

    // Load port: one registered write per accepted byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_we   <= 1'b0;
            load_sel  <= '0;
            load_addr <= '0;
            load_data <= '0;
        end else begin
            load_we <= accept;
            if (accept) begin
                load_sel  <= address;
                load_addr <= sel_cnt;
                load_data <= writedata;
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_LOAD;
            layer_idx   <= '0;
            timer       <= '0;
            layer_start <= '0;
            buf_sel     <= 1'b0;
            res_idx     <= '0;
            irq         <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (clear) begin
            state       <= ST_LOAD;
            layer_idx   <= '0;
            timer       <= '0;
            layer_start <= '0;
            buf_sel     <= 1'b0;
            res_idx     <= '0;
            irq         <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            // Status read acknowledges the interrupt; a same-cycle raise
            // below still wins.
            if (rd && (address == ADDR_STATUS)) begin
                irq <= 1'b0;
            end
            case (state)
                ST_LOAD: begin
                    if (go) begin
                        layer_idx   <= '0;
                        layer_start <= layer_onehot(2'd0);
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    layer_start <= '0;
                    timer       <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Only the running layer's done bit matters.
                    if (layer_done[layer_idx]) begin
                        buf_sel <= ~buf_sel;
                        if (layer_idx == 2'd3) begin
                            res_idx <= '0;
                            irq     <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            layer_idx   <= layer_idx + 2'd1;
                            layer_start <= layer_onehot(layer_idx + 2'd1);
                            state       <= ST_START;
                        end
                    end else if (timer == TIMER_MAX) begin
                        irq   <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DONE: begin
                    if (rd && (address == ADDR_RESULT)) begin
                        res_idx <= (res_idx == RES_LAST) ? '0 : res_idx + RW'(1);
                    end
                end
                ST_ERR: begin
                    // Held until clear or reset.
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Read path. Result reads forward res_rdata in the cycle after the read,
    // then capture it so readdata holds afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            rd_res_q   <= 1'b0;
        end else begin
            rd_res_q <= 1'b0;
            if (rd_res_q) begin
                readdata_q <= res_rdata;
            end
            if (rd) begin
                case (address)
                    ADDR_STATUS: readdata_q <= status;
                    ADDR_RESULT: begin
                        if (state == ST_DONE) begin
                            rd_res_q <= 1'b1;
                        end else begin
                            readdata_q <= '0;
                        end
                    end
                    default: readdata_q <= '0;
                endcase
            end
        end
    end

    assign readdata = rd_res_q ? res_rdata : readdata_q;

endmodule

// File: doc/cnn_sequencer.md
Name: cnn_sequencer

Overview:
- Control/sequencing block for the CNN memory subsystem.
- Accepts bus byte-writes and steers them into the input and four weight RAMs, with per-region fill counters.
- After a software "go", runs layers 1..4 in order using a start/done handshake and a ping-pong activation buffer.
- Exposes status, an interrupt and auto-incrementing result readout to the host.

Parameters:
ADDR_W, 19, width of every RAM address
INPUT_SIZE, 10000, bytes in input image region
L1_SIZE, 400, layer-1 weight bytes
L2_SIZE, 12800, layer-2 weight bytes
L3_SIZE, 230400, layer-3 weight bytes
L4_SIZE, 10600, layer-4 weight bytes
RESULT_SIZE, 53, result bytes readable after completion
TIMEOUT_CYCLES, 2**24, maximum cycles allowed per layer before error

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
chipselect  in  1  bus select
write  in  1  bus write strobe
read  in  1  bus read strobe
address  in  3  register select: 0..4 load regions (input, L1..L4), 5 control, 6 status, 7 result
writedata  in  8  bus write data
readdata  out  8  bus read data, read latency 1
load_we  out  1  RAM write enable, one-cycle pulse
load_sel  out  3  target region 0..4
load_addr  out  ADDR_W  RAM write address
load_data  out  8  RAM write data
layer_start  out  4  one-hot start pulse, bit k = layer k+1
layer_done  in  4  one-cycle done pulse per layer
buf_sel  out  1  ping-pong buffer holding the current layer's source
res_addr  out  ADDR_W  result RAM read address
res_rdata  in  8  result RAM data, one cycle after res_addr
irq  out  1  level interrupt

Behaviour:
- Reset values: all outputs 0, all fill counters 0, state LOAD, sticky flags clear.
- Reset mid-run: layer_start drops immediately; the run is abandoned.
- Load path, address 0..4, state LOAD only:
  - A write to region r with cnt[r] < SIZE[r] registers load_we=1, load_sel=r, load_addr=cnt[r], load_data=writedata in the next cycle, then increments cnt[r].
  - A write with cnt[r] == SIZE[r] is dropped and sets the sticky ovf flag.
  - Load writes outside LOAD are dropped and set ovf.
- Region r is loaded when cnt[r] == SIZE[r].
- Control register, address 5:
  - bit0 go: accepted only in LOAD with all five regions loaded; otherwise ignored.
  - bit1 clear: from any state, zeroes counters, flags, buf_sel and res index, deasserts irq and returns to LOAD.
  - clear and go written together: clear wins.
- Status register, address 6: [4:0] loaded flags, [5] busy, [6] done, [7] err|ovf. Reading it deasserts irq.
- Result register, address 7:
  - Valid only in DONE; readdata = res_rdata in the cycle after read.
  - res index then increments and wraps RESULT_SIZE-1 -> 0.
  - Outside DONE, reads return 0.
- FSM states and transitions:
  - LOAD: on accepted go, k=0 -> START.
  - START: layer_start[k]=1 for exactly one cycle, timer cleared -> WAIT.
  - WAIT: on layer_done[k], buf_sel toggles; if k<3 then k++ -> START, else -> DONE.
  - WAIT timeout: timer reaching TIMEOUT_CYCLES-1 -> ERR.
  - DONE: irq=1 until status read or clear; res_addr = output-buffer base plus res index.
  - ERR: err=1, irq=1; exit only via clear or reset.
- layer_done handling:
  - Sampled only in WAIT; a pulse in the START cycle is ignored.
  - Pulses on bits other than k are ignored and are not an error.
- Bus rules:
  - Read and write asserted in the same cycle: write is processed, read ignored, readdata holds.
  - busy = state in {START, WAIT}.
- buf_sel after four layers returns to 0; the result lives in buffer 0.

Decomposition:
- Package cnn_pkg:
  - state enum {LOAD, START, WAIT, DONE, ERR}
  - register-address constants
  - region-size constants
  - status bit indices
- One sub-module: cnn_region_counter, a saturating fill counter with full flag and overflow strobe, instantiated 5 times.

Test Plan:
- Reset, then read status -> readdata 8'h00, irq 0, layer_start 0.
- Write 400 bytes to address 1 -> load_addr 0..399 on consecutive load_we pulses with load_sel=1, status[1]=1; a 401st write -> no load_we, status[7]=1.
- Load all regions, write go, model done 10 cycles after each start -> layer_start 4'b0001, 0010, 0100, 1000 in order; buf_sel toggles 4 times; status=8'h5F; irq=1 until status read.
- Go with L3 region unfilled -> state stays LOAD, no layer_start, status[5]=0.
- Run with layer 2 never returning done, TIMEOUT_CYCLES=16 -> ERR 16 cycles after start; status[7]=1; irq=1; write clear -> status 0, irq 0.
- In DONE, 54 reads of address 7 -> res index 0..52 then back to 0; readdata equals res_rdata each cycle after its read.
